// File: rtl/dbus_arbiter.sv
// dbus_arbiter: round-robin sharing of one data bus among NREQ requesters.
// The winner's request is latched and owns the bus until downstream data_ok.
package dbus_pkg;
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter int NREQ           = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IW            = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  dbus_req_t  [NREQ-1:0] ireq,
    output dbus_resp_t [NREQ-1:0] iresp,
    output dbus_req_t             oreq,
    input  dbus_resp_t            oresp,
    output logic                  busy,
    output logic [IW-1:0]         owner,
    output logic                  timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CW-1:0] CMAX = CW'(TIMEOUT_CYCLES);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [IW-1:0]   last_grant;
    dbus_req_t       req_q;
    logic [CW-1:0]   cnt;
    logic            found;
    logic [IW-1:0]   win;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Round-robin scan, next state and bus/response muxing
    always_comb begin
        state_n = state;
        found   = 1'b0;
        win     = '0;
        oreq    = '0;
        iresp   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && ireq[(int'(last_grant) + 1 + k) % NREQ].valid) begin
                found = 1'b1;
                win   = IW'((int'(last_grant) + 1 + k) % NREQ);
            end
        end
        unique case (state)
            IDLE: begin
                if (found) state_n = BUSY;
            end
            BUSY: begin
                oreq         = req_q;
                iresp[owner] = oresp;
                if (oresp.data_ok) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Grant bookkeeping, latched request and watchdog
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner      <= '0;
            last_grant <= IW'(NREQ - 1);
            req_q      <= '0;
            cnt        <= '0;
            timeout    <= 1'b0;
        end else if (state == IDLE) begin
            if (found) begin
                owner       <= win;
                req_q       <= ireq[win];
                req_q.valid <= 1'b1;
                cnt         <= '0;
            end
        end else if (oresp.data_ok) begin
            last_grant <= owner;
        end else if (TIMEOUT_CYCLES != 0) begin
            if (cnt != CMAX) cnt <= cnt + CW'(1);
            if (cnt + CW'(1) == CMAX) timeout <= 1'b1;
        end
    end

    // Busy is a decode of the registered state
    assign busy = (state == BUSY);

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter with a request scoreboard.
// A second instance with the watchdog disabled shares the stimulus.
module tb_dbus_arbiter;
    import dbus_pkg::*;

    logic                  clk;
    logic                  reset;
    dbus_req_t  [1:0]      ireq;
    dbus_resp_t [1:0]      iresp;
    dbus_resp_t [1:0]      iresp0;
    dbus_req_t             oreq;
    dbus_req_t             oreq0;
    dbus_resp_t            oresp;
    logic                  busy;
    logic                  busy0;
    logic [0:0]            owner;
    logic [0:0]            owner0;
    logic                  timeout;
    logic                  timeout0;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    dbus_req_t  sb_req[$];
    logic [0:0] sb_own[$];

    dbus_arbiter #(.NREQ(2), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp),
        .oreq(oreq), .oresp(oresp), .busy(busy), .owner(owner),
        .timeout(timeout)
    );

    dbus_arbiter #(.NREQ(2), .TIMEOUT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp0),
        .oreq(oreq0), .oresp(oresp), .busy(busy0), .owner(owner0),
        .timeout(timeout0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic dbus_req_t mk(input logic [63:0] a, input msize_t s,
                                     input logic [7:0] st, input logic [63:0] d);
        dbus_req_t r;
        r.valid  = 1'b1;
        r.addr   = a;
        r.size   = s;
        r.strobe = st;
        r.data   = d;
        return r;
    endfunction

    task automatic push(input dbus_req_t r, input logic [0:0] p);
        sb_req.push_back(r);
        sb_own.push_back(p);
    endtask

    // Wait (bounded) for a grant, then pop and compare the scoreboard
    task automatic check_grant(input string tag);
        int c;
        dbus_req_t er;
        logic [0:0] eo;
        c = 0;
        while (!oreq.valid && c < 8) begin
            tick();
            c++;
        end
        chk({tag, "_valid"}, 256'(oreq.valid), 256'(1'b1));
        if (sb_req.size() == 0) begin
            chk({tag, "_sb_empty"}, 256'(1'b1), 256'(1'b0));
        end else begin
            er = sb_req.pop_front();
            eo = sb_own.pop_front();
            chk({tag, "_req"}, 256'(oreq), 256'(er));
            chk({tag, "_owner"}, 256'(owner), 256'(eo));
            chk({tag, "_busy"}, 256'(busy), 256'(1'b1));
        end
    endtask

    // One quick transaction on a single port with immediate data_ok
    task automatic xact(input string tag, input int p, input dbus_req_t r,
                        input logic [63:0] rd);
        ireq[p] = r;
        push(r, 1'(p));
        check_grant(tag);
        ireq[p].valid = 1'b0;
        oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: rd};
        #1;
        chk({tag, "_dok"}, 256'(iresp[p]), 256'(oresp));
        tick();
        oresp = '0;
        #1;
        chk({tag, "_idle"}, 256'(busy), 256'(1'b0));
    endtask

    dbus_req_t r0;
    dbus_req_t r1;

    initial begin
        reset = 1'b0;
        ireq  = '0;
        oresp = '0;
        #1;
        chk("rst_oreq", 256'(oreq), 256'(0));
        chk("rst_iresp", 256'(iresp), 256'(0));
        chk("rst_busy", 256'(busy), 256'(1'b0));
        chk("rst_owner", 256'(owner), 256'(1'b0));
        chk("rst_timeout", 256'(timeout), 256'(1'b0));
        tick();
        tick();
        reset = 1'b1;

        // Single store on port 0, data_ok 3 cycles after oreq.valid
        r0 = mk(64'h8000_0010, MSIZE8, 8'hff, 64'h1122334455667788);
        ireq[0] = r0;
        push(r0, 1'b0);
        tick();
        chk("t1_latency", 256'(oreq.valid), 256'(1'b1));
        check_grant("t1");
        ireq[0].valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("t1_busy", 256'(busy), 256'(1'b1));
            chk("t1_nodok", 256'(iresp[0].data_ok), 256'(1'b0));
        end
        tick();
        oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h0};
        #1;
        chk("t1_dok", 256'(iresp[0].data_ok), 256'(1'b1));
        chk("t1_other", 256'(iresp[1]), 256'(0));
        tick();
        oresp = '0;
        #1;
        chk("t1_busy_end", 256'(busy), 256'(1'b0));
        chk("t1_oreq_end", 256'(oreq.valid), 256'(1'b0));
        chk("t1_iresp_end", 256'(iresp[0]), 256'(0));

        // Both ports valid, data_ok immediate, from a fresh reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        r0 = mk(64'h1000, MSIZE4, 8'h0f, 64'haaaa);
        r1 = mk(64'h2000, MSIZE8, 8'hff, 64'hbbbb);
        ireq[0] = r0;
        ireq[1] = r1;
        oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h55};
        for (int i = 0; i < 4; i++) push((i % 2 == 0) ? r0 : r1, 1'(i % 2));
        for (int i = 0; i < 4; i++) begin
            check_grant("t2");
            chk("t2_route", 256'(iresp[i % 2].data_ok), 256'(1'b1));
            chk("t2_nonowner", 256'(iresp[1 - i % 2]), 256'(0));
            tick();
            chk("t2_idle", 256'(busy), 256'(1'b0));
        end
        ireq = '0;
        oresp = '0;
        tick();

        // Port 1 payload changes while BUSY are ignored
        r1 = mk(64'h100, MSIZE8, 8'h00, 64'h0);
        ireq[1] = r1;
        push(r1, 1'b1);
        check_grant("t3");
        ireq[1].addr = 64'h200;
        ireq[1].data = 64'h9999;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("t3_addr_hold", 256'(oreq.addr), 256'(64'h100));
        end
        oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hdeadbeef};
        #1;
        chk("t3_data", 256'(iresp[1].data), 256'(64'hdeadbeef));
        chk("t3_dok", 256'(iresp[1].data_ok), 256'(1'b1));
        chk("t3_p0_zero", 256'(iresp[0]), 256'(0));
        chk("t3_addr_last", 256'(oreq.addr), 256'(64'h100));
        tick();
        ireq = '0;
        oresp = '0;
        tick();

        // Watchdog: data_ok withheld 10 cycles
        r0 = mk(64'h3000, MSIZE8, 8'hff, 64'h1);
        ireq[0] = r0;
        push(r0, 1'b0);
        check_grant("t4");
        ireq[0].valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("t4_timeout", 256'(timeout), 256'(k >= 8));
            chk("t4_timeout_off", 256'(timeout0), 256'(1'b0));
        end
        oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h0};
        tick();
        oresp = '0;
        #1;
        chk("t4_sticky", 256'(timeout), 256'(1'b1));
        xact("t4b", 1, mk(64'h3008, MSIZE8, 8'hff, 64'h2), 64'h7);
        chk("t4_sticky2", 256'(timeout), 256'(1'b1));
        chk("t4_off2", 256'(timeout0), 256'(1'b0));

        // Reset mid-BUSY; port 0 wins first afterwards
        xact("t5a", 0, mk(64'h4000, MSIZE8, 8'hff, 64'h3), 64'h8);
        r1 = mk(64'h4100, MSIZE8, 8'hff, 64'h4);
        ireq[1] = r1;
        push(r1, 1'b1);
        check_grant("t5b");
        #2;
        reset = 1'b0;
        #1;
        chk("t5_oreq", 256'(oreq.valid), 256'(1'b0));
        chk("t5_busy", 256'(busy), 256'(1'b0));
        chk("t5_timeout", 256'(timeout), 256'(1'b0));
        tick();
        reset = 1'b1;
        r0 = mk(64'h5000, MSIZE2, 8'h03, 64'h5);
        ireq[0] = r0;
        push(r0, 1'b0);
        check_grant("t5c");
        ireq = '0;
        oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h0};
        tick();
        oresp = '0;
        tick();

        // Owner drops valid in 2nd BUSY cycle, data_ok in 4th
        r1 = mk(64'h6000, MSIZE8, 8'hff, 64'h6);
        ireq[1] = r1;
        push(r1, 1'b1);
        check_grant("t6");
        tick();
        ireq[1].valid = 1'b0;
        #1;
        chk("t6_busy2", 256'(busy), 256'(1'b1));
        tick();
        chk("t6_busy3", 256'(busy), 256'(1'b1));
        tick();
        oresp = '{addr_ok: 1'b0, data_ok: 1'b1, data: 64'hcafe};
        #1;
        chk("t6_dok", 256'(iresp[1].data_ok), 256'(1'b1));
        chk("t6_data", 256'(iresp[1].data), 256'(64'hcafe));
        tick();
        oresp = '0;
        r0 = mk(64'h7000, MSIZE8, 8'hff, 64'h7);
        ireq[0] = r0;
        ireq[1] = mk(64'h7100, MSIZE8, 8'hff, 64'h8);
        push(r0, 1'b0);
        check_grant("t6_next");
        ireq = '0;
        oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h0};
        tick();
        oresp = '0;
        tick();
        chk("end_sb_empty", 256'(sb_req.size()), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
